// File: rtl/serial_tx_if.sv
// Byte handshake between an upstream producer and serial_tx.
// The producer drives valid/data; the transmitter answers with ready.
interface serial_tx_if;
    logic       valid;
    logic [7:0] data;
    logic       ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/serial_tx.sv
// Serial frame transmitter: start bit, eight data bits LSB first, optional odd parity, stop bit.
// Accepts one byte per frame over a valid/ready handshake; back-to-back frames have no idle gap.
module serial_tx #(
    parameter int CLKS_PER_BIT = 1,
    parameter bit PARITY_EN    = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    serial_tx_if.slave   up,
    output logic         tx,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state;
    logic [15:0] timer;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        parity;
    logic        bit_end;
    logic        accept;

    assign bit_end = (timer == LAST);

    // NOTE: ready is decoded from registered state so an accept can land in the last stop cycle;
    // it is gated by reset so nothing is taken while the block is being cleared.
    assign up.ready = !reset && ((state == IDLE) || (state == STOP && bit_end));
    assign accept   = up.valid && up.ready;

    // NOTE: all state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
            parity  <= 1'b0;
        end else if (accept) begin
            state   <= START;
            shift   <= up.data;
            parity  <= ~^up.data;
            tx      <= 1'b0;
            busy    <= 1'b1;
            done    <= 1'b0;
            timer   <= '0;
            bit_idx <= '0;
        end else if (state != IDLE) begin
            if (!bit_end) begin
                timer <= timer + 16'd1;
                done  <= (state == STOP) && (timer + 16'd1 == LAST);
            end else begin
                timer <= '0;
                done  <= 1'b0;
                case (state)
                    START: begin
                        state <= DATA;
                        tx    <= shift[0];
                    end
                    DATA: begin
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            if (PARITY_EN) begin
                                state <= PARITY;
                                tx    <= parity;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                                done  <= (LAST == 16'd0);
                            end
                        end else begin
                            tx <= shift[1];
                        end
                    end
                    PARITY: begin
                        state <= STOP;
                        tx    <= 1'b1;
                        done  <= (LAST == 16'd0);
                    end
                    default: begin
                        // End of stop bit with no new byte offered.
                        state <= IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
